// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the 4-way TDM demultiplexer
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

endpackage

// File: rtl/slot_decoder.sv
// rtl/slot_decoder.sv - 2-to-4 one-hot decoder with enable, drives channel write enables
module slot_decoder (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] we
);

  always_comb begin
    we = 4'b0000;
    if (en) begin
      we[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - TDM receive demux: slot tracking FSM, per-channel registers, sync error counting
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic [3:0]       ch_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] sync_err_cnt
);

  state_t              r_state;
  state_t              w_next_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [SLOT_W-1:0]   w_next_slot;
  logic [SLOT_W-1:0]   w_wslot;
  logic                w_accept;
  logic                w_sync_err;
  logic                w_frame_done;
  logic [NCH-1:0]      w_we;

  logic [WIDTH-1:0]    r_ch_data [NCH];
  logic [NCH-1:0]      r_ch_valid;
  logic                r_frame_done;
  logic                r_locked;
  logic                r_sync_err;
  logic [ERR_W-1:0]    r_sync_err_cnt;

  // A sync-flagged sample always lands in slot 0, regardless of where the counter was.
  assign w_wslot = frame_sync ? '0 : r_slot;

  always_comb begin
    w_next_state = r_state;
    w_next_slot  = r_slot;
    w_accept     = 1'b0;
    w_sync_err   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      HUNT: begin
        if (din_valid && frame_sync) begin
          w_accept     = 1'b1;
          w_next_slot  = SLOT_W'(1);
          w_next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (frame_sync) begin
            // Early sync truncates the frame but keeps lock.
            w_accept    = 1'b1;
            w_next_slot = SLOT_W'(1);
            w_sync_err  = (r_slot != '0);
          end else if (r_slot == '0) begin
            w_sync_err   = 1'b1;
            w_next_slot  = '0;
            w_next_state = HUNT;
          end else begin
            w_accept     = 1'b1;
            w_next_slot  = r_slot + SLOT_W'(1);
            w_frame_done = (r_slot == SLOT_W'(3));
          end
        end
      end
      default: begin
        w_next_state = HUNT;
        w_next_slot  = '0;
      end
    endcase
  end

  slot_decoder u_slot_decoder (
    .sel (w_wslot),
    .en  (w_accept),
    .we  (w_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= HUNT;
      r_slot         <= '0;
      r_ch_valid     <= '0;
      r_frame_done   <= 1'b0;
      r_locked       <= 1'b0;
      r_sync_err     <= 1'b0;
      r_sync_err_cnt <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_ch_data[k] <= '0;
      end
    end else begin
      r_state      <= w_next_state;
      r_slot       <= w_next_slot;
      r_ch_valid   <= w_we;
      r_frame_done <= w_frame_done;
      r_locked     <= (w_next_state == LOCKED);
      r_sync_err   <= w_sync_err;
      if (w_sync_err && (r_sync_err_cnt != {ERR_W{1'b1}})) begin
        r_sync_err_cnt <= r_sync_err_cnt + ERR_W'(1);
      end
      for (int k = 0; k < NCH; k++) begin
        if (w_we[k]) begin
          r_ch_data[k] <= din;
        end
      end
    end
  end

  assign ch0_data     = r_ch_data[0];
  assign ch1_data     = r_ch_data[1];
  assign ch2_data     = r_ch_data[2];
  assign ch3_data     = r_ch_data[3];
  assign ch_valid     = r_ch_valid;
  assign frame_done   = r_frame_done;
  assign locked       = r_locked;
  assign sync_err     = r_sync_err;
  assign sync_err_cnt = r_sync_err_cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;

  logic [7:0] ch0_data, ch1_data, ch2_data, ch3_data;
  logic [3:0] ch_valid;
  logic       frame_done, locked, sync_err;
  logic [7:0] sync_err_cnt;

  logic [7:0] s_ch0, s_ch1, s_ch2, s_ch3;
  logic [3:0] s_ch_valid;
  logic       s_frame_done, s_locked, s_sync_err;
  logic [1:0] s_sync_err_cnt;

  int checks;
  int failures;

  tdm_demux4 #(.WIDTH(8), .ERR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .frame_sync   (frame_sync),
    .ch0_data     (ch0_data),
    .ch1_data     (ch1_data),
    .ch2_data     (ch2_data),
    .ch3_data     (ch3_data),
    .ch_valid     (ch_valid),
    .frame_done   (frame_done),
    .locked       (locked),
    .sync_err     (sync_err),
    .sync_err_cnt (sync_err_cnt)
  );

  tdm_demux4 #(.WIDTH(8), .ERR_W(2)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .frame_sync   (frame_sync),
    .ch0_data     (s_ch0),
    .ch1_data     (s_ch1),
    .ch2_data     (s_ch2),
    .ch3_data     (s_ch3),
    .ch_valid     (s_ch_valid),
    .frame_done   (s_frame_done),
    .locked       (s_locked),
    .sync_err     (s_sync_err),
    .sync_err_cnt (s_sync_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [7:0] d, input logic v, input logic fs);
    @(negedge clk);
    din        = d;
    din_valid  = v;
    frame_sync = fs;
    @(posedge clk);
    #1;
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  // Sample point is #1 after the edge; step() returns at the following negedge,
  // so outputs are checked while still stable from the accepting edge.
  task automatic send(input logic [7:0] d, input logic fs);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = fs;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle();
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data actual=%h required=%h", {ch0_data, ch1_data, ch2_data, ch3_data}, 32'h0);
    end
    checks++;
    if ({ch_valid, frame_done, locked, sync_err, sync_err_cnt} !== 15'h0) begin
      failures++;
      $display("FAIL reset_flags actual=%h required=%h", {ch_valid, frame_done, locked, sync_err, sync_err_cnt}, 15'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [7:0] vals [4];
    vals[0] = 8'hA0; vals[1] = 8'hA1; vals[2] = 8'hA2; vals[3] = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], (i == 0));
      checks++;
      if (ch_valid !== (4'b0001 << i)) begin
        failures++;
        $display("FAIL frame_ch_valid%0d actual=%b required=%b", i, ch_valid, 4'b0001 << i);
      end
      checks++;
      if (frame_done !== (i == 3)) begin
        failures++;
        $display("FAIL frame_done%0d actual=%b required=%b", i, frame_done, (i == 3));
      end
      checks++;
      if (locked !== 1'b1) begin
        failures++;
        $display("FAIL frame_locked%0d actual=%b required=1", i, locked);
      end
    end
    checks++;
    if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 32'hA0A1A2A3) begin
      failures++;
      $display("FAIL frame_data actual=%h required=A0A1A2A3", {ch0_data, ch1_data, ch2_data, ch3_data});
    end
    idle();
    checks++;
    if ({ch_valid, frame_done, sync_err} !== 6'b0) begin
      failures++;
      $display("FAIL frame_pulses_clear actual=%b required=000000", {ch_valid, frame_done, sync_err});
    end
  endtask

  task automatic test_missing_sync();
    send(8'h55, 1'b0);
    checks++;
    if ({sync_err, locked, ch_valid} !== 6'b100000) begin
      failures++;
      $display("FAIL missing_sync_flags actual=%b required=100000", {sync_err, locked, ch_valid});
    end
    checks++;
    if (sync_err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL missing_sync_cnt actual=%0d required=1", sync_err_cnt);
    end
    checks++;
    if (ch0_data !== 8'hA0) begin
      failures++;
      $display("FAIL missing_sync_ch0 actual=%h required=A0", ch0_data);
    end
    idle();
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL missing_sync_pulse actual=%b required=0", sync_err);
    end
  endtask

  task automatic test_hunt();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    checks++;
    if ({ch_valid, locked, sync_err} !== 6'b0 || ch0_data !== 8'hA0) begin
      failures++;
      $display("FAIL hunt_drop actual=%b/%h required=000000/A0", {ch_valid, locked, sync_err}, ch0_data);
    end
    send(8'h33, 1'b1);
    checks++;
    if (ch0_data !== 8'h33 || ch_valid !== 4'b0001 || locked !== 1'b1) begin
      failures++;
      $display("FAIL hunt_relock actual=%h/%b/%b required=33/0001/1", ch0_data, ch_valid, locked);
    end
  endtask

  task automatic test_early_sync();
    send(8'h44, 1'b0);
    checks++;
    if (ch1_data !== 8'h44 || ch_valid !== 4'b0010) begin
      failures++;
      $display("FAIL early_slot1 actual=%h/%b required=44/0010", ch1_data, ch_valid);
    end
    send(8'h77, 1'b1);
    checks++;
    if ({sync_err, frame_done, locked, ch_valid} !== 7'b1010001) begin
      failures++;
      $display("FAIL early_flags actual=%b required=1010001", {sync_err, frame_done, locked, ch_valid});
    end
    checks++;
    if ({ch0_data, ch2_data, ch3_data} !== 24'h77A2A3 || sync_err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL early_data actual=%h cnt=%0d required=77A2A3 cnt=2", {ch0_data, ch2_data, ch3_data}, sync_err_cnt);
    end
    send(8'h88, 1'b0);
    checks++;
    if (ch1_data !== 8'h88 || ch_valid !== 4'b0010 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL early_continue actual=%h/%b/%b required=88/0010/0", ch1_data, ch_valid, sync_err);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ch0_data, ch1_data, ch2_data, ch3_data, ch_valid, frame_done, locked, sync_err, sync_err_cnt} !== 47'h0) begin
      failures++;
      $display("FAIL async_reset actual=%h required=0",
               {ch0_data, ch1_data, ch2_data, ch3_data, ch_valid, frame_done, locked, sync_err, sync_err_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h99, 1'b0);
    checks++;
    if ({ch_valid, locked, sync_err} !== 6'b0 || ch1_data !== 8'h00) begin
      failures++;
      $display("FAIL after_reset_nosync actual=%b/%h required=000000/00", {ch_valid, locked, sync_err}, ch1_data);
    end
  endtask

  task automatic test_err_saturation();
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      send(8'hC0, 1'b1);
      send(8'hC1, 1'b0);
      send(8'hC2, 1'b0);
      send(8'hC3, 1'b0);
      send(8'hEE, 1'b0);
      checks++;
      if (s_sync_err_cnt !== exp_sat[i] || s_sync_err !== 1'b1) begin
        failures++;
        $display("FAIL sat_cnt%0d actual=%0d/%b required=%0d/1", i, s_sync_err_cnt, s_sync_err, exp_sat[i]);
      end
      checks++;
      if (sync_err_cnt !== 8'(i + 1)) begin
        failures++;
        $display("FAIL wide_cnt%0d actual=%0d required=%0d", i, sync_err_cnt, i + 1);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    din        = 8'h00;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst_n      = 1'b0;
    test_reset();
    test_frame();
    test_missing_sync();
    test_hunt();
    test_early_sync();
    test_async_reset();
    test_err_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
